// File: rtl/gray_codec_pipe.sv
// Registered Gray-code engine: binary<->Gray conversion, Gray adjacency check
// and a free-running Gray counter behind a single valid/ready output stage.
module gray_codec_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             adj_err
);

    typedef enum logic [1:0] {
        MODE_B2G   = 2'b00,
        MODE_G2B   = 2'b01,
        MODE_CHECK = 2'b10,
        MODE_COUNT = 2'b11
    } mode_t;

    // Handshake: a word moves on a side only in a cycle where that side's valid
    // and ready are both high; valid never depends on ready, and the output
    // register may reload in the same cycle it is drained.
    logic in_fire;

    logic [WIDTH-1:0] gray_count;
    logic [WIDTH-1:0] prev_word;
    logic             hist_valid;

    logic [WIDTH-1:0] result_data;
    logic             result_err;
    mode_t            cur_mode;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] to_binary(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned bit_count(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign cur_mode = mode_t'(mode);

    always_comb begin
        result_data = '0;
        result_err  = 1'b0;
        unique case (cur_mode)
            MODE_B2G:   result_data = to_gray(in_data);
            MODE_G2B:   result_data = to_binary(in_data);
            MODE_CHECK: begin
                result_data = to_binary(in_data);
                // A hold (no bits changed) is a legal Gray step.
                result_err  = hist_valid && (bit_count(in_data ^ prev_word) > 1);
            end
            MODE_COUNT: result_data = gray_count;
            default:    result_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            adj_err    <= 1'b0;
            gray_count <= '0;
            prev_word  <= '0;
            hist_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= result_data;
            adj_err   <= result_err;
            if (cur_mode == MODE_CHECK) begin
                prev_word  <= in_data;
                hist_valid <= 1'b1;
            end else begin
                hist_valid <= 1'b0;
            end
            if (cur_mode == MODE_COUNT) begin
                gray_count <= to_gray(to_binary(gray_count) + WIDTH'(1));
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe (WIDTH=4): directed vector table, stall and reset
// sequences, then randomized traffic scored against a behavioural model.
module tb_gray_codec_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         adj_err;

    gray_codec_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .adj_err(adj_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [W:0] exp_q[$];     // {adj_err, out_data}
    int         m_count;      // counter position as a plain integer
    int         m_prev;
    bit         m_hist;

    function automatic int gray_of(input int n);
        return n ^ (n >> 1);
    endfunction

    // Binary value whose Gray code equals g, found by search.
    function automatic int binary_of(input int g);
        for (int n = 0; n < (1 << W); n++) begin
            if (gray_of(n) == g) return n;
        end
        return -1;
    endfunction

    task automatic model_accept(input logic [1:0] m, input logic [W-1:0] d);
        int e;
        bit err;
        err = 1'b0;
        case (m)
            2'b00: e = gray_of(int'(d));
            2'b01: e = binary_of(int'(d));
            2'b10: begin
                e   = binary_of(int'(d));
                err = m_hist && ($countones(int'(d) ^ m_prev) > 1);
            end
            default: begin
                e       = gray_of(m_count);
                m_count = (m_count + 1) % (1 << W);
            end
        endcase
        if (m == 2'b10) begin
            m_prev = int'(d);
            m_hist = 1'b1;
        end else begin
            m_hist = 1'b0;
        end
        exp_q.push_back({err, e[W-1:0]});
    endtask

    // Scoreboard: sample mid-cycle, consume before produce.
    always @(negedge clk) begin
        logic [W:0] exp;
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_prev  = 0;
            m_hist  = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", {adj_err, out_data}, 32'hFFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_output", {adj_err, out_data}, exp);
                end
            end
            if (in_valid && in_ready) model_accept(mode, in_data);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]   m;
        logic [W-1:0] d;
        logic [W-1:0] e;
        logic         err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] m, input logic [W-1:0] d,
                       input logic [W-1:0] e, input logic err);
        vec_t v;
        v.m = m; v.d = d; v.e = e; v.err = err;
        vecs.push_back(v);
    endtask

    // Present one word with out_ready high; result must appear next cycle.
    task automatic drive(input logic [1:0] m, input logic [W-1:0] d);
        mode     = m;
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [W-1:0] cseq[17];
        rst = 1'b1; mode = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_adj_err", adj_err, 0);
        check("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        add(2'b00, 4'h0, 4'h0, 0); add(2'b00, 4'h1, 4'h1, 0); add(2'b00, 4'h3, 4'h2, 0);
        add(2'b00, 4'h6, 4'h5, 0); add(2'b00, 4'hB, 4'hE, 0); add(2'b00, 4'hF, 4'h8, 0);
        add(2'b01, 4'hE, 4'hB, 0); add(2'b01, 4'h8, 4'hF, 0); add(2'b01, 4'h5, 4'h6, 0);
        cseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        for (int i = 0; i < 17; i++) add(2'b11, W'($urandom), cseq[i], 0);
        add(2'b10, 4'h0, 4'h0, 0); add(2'b10, 4'h1, 4'h1, 0); add(2'b10, 4'h1, 4'h1, 0);
        add(2'b10, 4'h3, 4'h2, 0); add(2'b10, 4'h6, 4'h4, 1); add(2'b10, 4'h7, 4'h5, 0);
        add(2'b00, 4'h0, 4'h0, 0);
        add(2'b10, 4'hF, 4'hA, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].m, vecs[i].d);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].e);
            check($sformatf("vec%0d_err", i), adj_err, vecs[i].err);
        end

        // Backpressure: counter sits at position 1 after the 17-count wrap.
        idle(1);
        out_ready = 1'b0;
        drive(2'b11, 4'h0);
        check("bp_load", out_data, 4'h1);
        for (int i = 0; i < 3; i++) begin
            mode = 2'(i); in_data = W'($urandom); in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_data_frozen", out_data, 4'h1);
            check("bp_err_frozen", adj_err, 0);
        end
        out_ready = 1'b1;
        drive(2'b11, 4'h0);
        check("bp_resume_count", out_data, 4'h3);

        // Reset mid-stream with a stalled count of 6 pending.
        drive(2'b11, 4'h0);
        check("rs_pre_count", out_data, 4'h2);
        drive(2'b11, 4'h0);
        out_ready = 1'b0;
        idle(1);
        check("rs_stalled_valid", out_valid, 1);
        check("rs_stalled_data", out_data, 4'h6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rs_valid_dropped", out_valid, 0);
        check("rs_data_cleared", out_data, 0);
        out_ready = 1'b1;
        drive(2'b11, 4'h0);
        check("rs_count_restart", out_data, 4'h0);
        drive(2'b10, 4'hF);
        check("rs_check_fresh", adj_err, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            mode      = 2'($urandom_range(0, 3));
            in_data   = ($urandom_range(0, 1) == 0) ? W'($urandom) : (in_data ^ W'(1 << $urandom_range(0, W - 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
- Parametrised, registered Gray-code engine that generalises the 4-bit binary-to-Gray converter to WIDTH bits.
- Four runtime modes:
  - binary-to-Gray
  - Gray-to-binary
  - Gray-to-binary with an adjacency check (flags illegal multi-bit Gray steps)
  - free Gray counter
- Valid/ready streaming interface with one output register stage.
- Sits between encoder/sync front-ends (position sensors, CDC pointers) and downstream binary logic.

Parameters:
WIDTH, 4, data width in bits (legal 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
mode  input  2  operation select, sampled on each accepted input transfer (00 B2G, 01 G2B, 10 CHECK, 11 COUNT)
in_valid  input  1  input word present
in_ready  output  1  block can accept input this cycle
in_data  input  WIDTH  input word (ignored in COUNT)
out_valid  output  1  out_data/adj_err valid
out_ready  input  1  downstream accepts output
out_data  output  WIDTH  converted word or counter value
adj_err  output  1  CHECK mode: current word is not a legal Gray step from the previous one; 0 in other modes

Behaviour:
- Interface decision: one clock, clk; synchronous, active-high reset, rst.
- Reset, on a clk edge with rst=1:
  - out_valid=0, out_data=0, adj_err=0.
  - Gray counter=0, check-history-valid=0.
  - Any held output is discarded.
  - rst has priority over all other inputs in that cycle.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational).
  - Throughput is 1 word/cycle when out_ready stays high.
- Latency:
  - Result is registered; out_valid rises the cycle after the input transfer.
  - out_data and adj_err hold stable while out_valid & !out_ready.
  - No input transfer and an output transfer in the same cycle: out_valid -> 0.
  - Simultaneous output and input transfer: register reloads with the new result; out_valid stays 1.
- B2G (00): out_data = in_data ^ (in_data >> 1).
- G2B (01): out_data[i] = XOR of in_data[WIDTH-1:i]; out_data[WIDTH-1] = in_data[WIDTH-1].
- CHECK (10):
  - out_data = G2B(in_data).
  - Let d = popcount(in_data ^ prev), where prev is the last in_data accepted in CHECK mode.
  - adj_err = 1 if history is valid and d > 1; d = 0 (hold) and d = 1 are legal.
  - First CHECK word after reset, or after any accepted non-CHECK transfer: adj_err = 0.
  - Every accepted CHECK word updates prev and sets history-valid.
  - Any accepted non-CHECK transfer clears history-valid.
- COUNT (11):
  - in_data is ignored.
  - Each accepted transfer outputs the current Gray count, then advances it: binary = G2B(count); count <= B2G(binary + 1) mod 2^WIDTH.
  - Wrap: Gray(2^WIDTH-1) -> 0.
  - Counter holds its value across mode changes; only rst clears it.
- Stall:
  - out_valid & !out_ready blocks input transfers; no state changes (counter, prev, history).
  - mode changes while stalled take effect on the next accepted transfer only.
- Reset mid-stream: a pending output is dropped; the first post-reset accepted word is treated as fresh (no adj_err; counter starts at 0).
- All arithmetic is unsigned WIDTH bits; the counter increment overflow bit is discarded.

Test Plan:
- WIDTH=4, out_ready=1, B2G, stream 0000,0001,0011,0110,1011,1111 -> out_data 0000,0001,0010,0101,1110,1000, one cycle after each input, out_valid continuous.
- G2B, stream 1110,1000,0101 -> 1011,1111,0110; adj_err stays 0.
- COUNT, 17 back-to-back transfers -> 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 (hex), wrap to 0 on the 17th.
- CHECK, stream 0000,0001,0001,0011,0110,0111 -> adj_err 0,0,0,0,1,0; out_data 0000,0001,0001,0010,0100,0101.
  - Then one B2G word, then CHECK 1111 -> adj_err 0 (history cleared).
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 and mode changing -> in_ready=0, out_data/adj_err frozen, counter unchanged.
  - Release -> transfers resume in order with no loss or duplication.
- Reset mid-stream: COUNT to value 6 with out_valid=1 and out_ready=0, pulse rst -> next cycle out_valid=0, and the next COUNT output is 0.
